// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory-busy stalls, taken-branch flushes
// and load-use bubbles, with saturating stall/flush performance counters.
module pipeline_hazard_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_RD,
  input  logic        EX_VALID,
  input  logic        EX_MEM_READ,
  input  logic        BRANCH_TAKEN,
  input  logic        IMEM_BUSY,
  input  logic        DMEM_BUSY,
  output logic        PC_STALL,
  output logic        IF_ID_STALL,
  output logic        ID_EX_STALL,
  output logic        EX_MEM_STALL,
  output logic        MEM_WB_STALL,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic [1:0]  STATE,
  output logic [15:0] STALL_COUNT,
  output logic [15:0] FLUSH_COUNT
);

  // state        | meaning
  // RUN          | normal flow, all hazards evaluated
  // LOAD_BUBBLE  | bubble sits in EX behind a load; load-use check suppressed
  // BRANCH_FLUSH | EX holds the flushed bubble; branch and load-use suppressed
  // MEM_WAIT     | a memory was busy last cycle; resumes like RUN once free
  localparam logic [1:0] RUN          = 2'd0;
  localparam logic [1:0] LOAD_BUBBLE  = 2'd1;
  localparam logic [1:0] BRANCH_FLUSH = 2'd2;
  localparam logic [1:0] MEM_WAIT     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic        busy;
  logic        load_use;

  assign busy = IMEM_BUSY | DMEM_BUSY;

  // Source-match terms are gated by the USES bits so unused fields cannot leak in.
  assign load_use = EX_VALID & EX_MEM_READ & (EX_RD != 5'd0) &
                    ((ID_USES_RS1 & (ID_RS1 == EX_RD)) |
                     (ID_USES_RS2 & (ID_RS2 == EX_RD)));

  always_comb begin
    PC_STALL     = 1'b0;
    IF_ID_STALL  = 1'b0;
    ID_EX_STALL  = 1'b0;
    EX_MEM_STALL = 1'b0;
    MEM_WB_STALL = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    state_d      = RUN;
    if (RESET) begin
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (busy) begin
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_STALL  = 1'b1;
      EX_MEM_STALL = 1'b1;
      MEM_WB_STALL = 1'b1;
      state_d      = MEM_WAIT;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
            state_d     = BRANCH_FLUSH;
          end else if (load_use) begin
            PC_STALL    = 1'b1;
            IF_ID_STALL = 1'b1;
            ID_EX_FLUSH = 1'b1;
            state_d     = LOAD_BUBBLE;
          end
        end
        LOAD_BUBBLE: begin
          if (BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
            state_d     = BRANCH_FLUSH;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (RESET) begin
      stall_count_d = 16'd0;
      flush_count_d = 16'd0;
    end else begin
      if (PC_STALL && (stall_count_q != 16'hFFFF))
        stall_count_d = stall_count_q + 16'd1;
      if (ID_EX_FLUSH && (flush_count_q != 16'hFFFF))
        flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    state_q       <= state_d;
    stall_count_q <= stall_count_d;
    flush_count_q <= flush_count_d;
  end

  assign STATE       = state_q;
  assign STALL_COUNT = stall_count_q;
  assign FLUSH_COUNT = flush_count_q;

endmodule
